// File: rtl/mod_sched_pkg.sv
// rtl/mod_sched_pkg.sv - shared types and constants for the modulo sequencer
package mod_sched_pkg;

   localparam int DEF_WIDTH = 8;

   // Wide all-ones pattern; users slice it to their own width for the
   // divide-by-zero quotient.
   localparam logic [63:0] ERR_QUOT_ALL = '1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SUB  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/mod_sched_if.sv
// rtl/mod_sched_if.sv - request/response handshake bundle for mod_sched
interface mod_sched_if #(
   parameter int WIDTH = 8
);
   logic             req0_valid;
   logic             req0_ready;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;
   logic             req1_valid;
   logic             req1_ready;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;
   logic             resp_valid;
   logic             resp_ready;
   logic             resp_id;
   logic [WIDTH-1:0] resp_quot;
   logic [WIDTH-1:0] resp_rem;
   logic             resp_err;

   // Requesters and result consumer
   modport master (
      output req0_valid, req0_a, req0_b,
      output req1_valid, req1_a, req1_b,
      output resp_ready,
      input  req0_ready, req1_ready,
      input  resp_valid, resp_id, resp_quot, resp_rem, resp_err
   );

   // Sequencer side
   modport slave (
      input  req0_valid, req0_a, req0_b,
      input  req1_valid, req1_a, req1_b,
      input  resp_ready,
      output req0_ready, req1_ready,
      output resp_valid, resp_id, resp_quot, resp_rem, resp_err
   );
endinterface

// File: rtl/mod_sched_dp.sv
// rtl/mod_sched_dp.sv - remainder/divisor/quotient registers with shared subtractor
module mod_sched_dp
   import mod_sched_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             CLK,
   input  logic             reset_n,
   input  logic             i_load,
   input  logic             i_step,
   input  logic             i_fill,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_rem,
   output logic [WIDTH-1:0] o_quot,
   output logic             o_less_than,
   output logic             o_div_zero
);

   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_div;
   logic [WIDTH-1:0] r_quot;
   logic [WIDTH-1:0] w_diff;

   // The subtractor is only used when rem >= div, so it never wraps.
   assign w_diff      = r_rem - r_div;
   assign o_less_than = (r_rem < r_div);
   assign o_div_zero  = (r_div == '0);
   assign o_rem       = r_rem;
   assign o_quot      = r_quot;

   // Operand load, error fill, or one subtraction step per cycle
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         r_rem  <= '0;
         r_div  <= '0;
         r_quot <= '0;
      end else if (i_load) begin
         r_rem  <= i_a;
         r_div  <= i_b;
         r_quot <= '0;
      end else if (i_fill) begin
         r_quot <= ERR_QUOT_ALL[WIDTH-1:0];
      end else if (i_step) begin
         r_rem  <= w_diff;
         r_quot <= r_quot + 1'b1;
      end
   end

endmodule

// File: rtl/mod_sched.sv
// rtl/mod_sched.sv - round-robin arbiter and sequencer for the shared modulo datapath
module mod_sched
   import mod_sched_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic     CLK,
   input  logic     reset_n,
   mod_sched_if.slave bus
);

   state_t           r_state;
   state_t           w_next;
   logic             r_last_grant;
   logic             r_id;
   logic             r_err;

   logic             w_any;
   logic             w_grant;
   logic             w_accept;
   logic             w_load;
   logic             w_step;
   logic             w_fill;
   logic [WIDTH-1:0] w_a;
   logic [WIDTH-1:0] w_b;
   logic [WIDTH-1:0] w_rem;
   logic [WIDTH-1:0] w_quot;
   logic             w_less_than;
   logic             w_div_zero;

   // Arbitration: a lone requester wins; on contention, alternate from last grant.
   // Ready is only raised toward a requester that is actually valid, so the
   // two readys are mutually exclusive by construction.
   always_comb begin
      w_any   = bus.req0_valid | bus.req1_valid;
      w_grant = 1'b0;
      if (bus.req0_valid && bus.req1_valid) begin
         w_grant = ~r_last_grant;
      end else begin
         w_grant = bus.req1_valid;
      end
      w_accept       = (r_state == IDLE) && w_any;
      bus.req0_ready = w_accept && (w_grant == 1'b0);
      bus.req1_ready = w_accept && (w_grant == 1'b1);
      w_a            = w_grant ? bus.req1_a : bus.req0_a;
      w_b            = w_grant ? bus.req1_b : bus.req0_b;
   end

   // Next-state and datapath control
   always_comb begin
      w_next = r_state;
      w_load = 1'b0;
      w_step = 1'b0;
      w_fill = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_load = 1'b1;
               w_next = SUB;
            end
         end
         SUB: begin
            if (w_div_zero) begin
               w_fill = 1'b1;
               w_next = DONE;
            end else if (!w_less_than) begin
               w_step = 1'b1;
            end else begin
               w_next = DONE;
            end
         end
         DONE: begin
            if (bus.resp_ready) begin
               w_next = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   // State register plus grant history, owner id and error flag
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= IDLE;
         r_last_grant <= 1'b1;
         r_id         <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_load) begin
            r_last_grant <= w_grant;
            r_id         <= w_grant;
            r_err        <= 1'b0;
         end else if (w_fill) begin
            r_err <= 1'b1;
         end
      end
   end

   mod_sched_dp #(
      .WIDTH (WIDTH)
   ) u_dp (
      .CLK         (CLK),
      .reset_n     (reset_n),
      .i_load      (w_load),
      .i_step      (w_step),
      .i_fill      (w_fill),
      .i_a         (w_a),
      .i_b         (w_b),
      .o_rem       (w_rem),
      .o_quot      (w_quot),
      .o_less_than (w_less_than),
      .o_div_zero  (w_div_zero)
   );

   // Response fields come straight from registers so they hold through backpressure.
   assign bus.resp_valid = (r_state == DONE);
   assign bus.resp_id    = r_id;
   assign bus.resp_quot  = w_quot;
   assign bus.resp_rem   = w_rem;
   assign bus.resp_err   = r_err;

endmodule

// File: tb/tb_mod_sched.sv
// tb/tb_mod_sched.sv - directed self-checking bench for mod_sched
module tb_mod_sched;

   logic CLK;
   logic reset_n;
   int   n_tests;
   int   n_fail;

   mod_sched_if #(.WIDTH(8)) bus ();

   mod_sched #(.WIDTH(8)) dut (
      .CLK     (CLK),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_resp(input string tag, input int exp_lat);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (bus.resp_valid !== 1'b1 && n < 400);
      check(tag, n, exp_lat);
   endtask

   task automatic check_resp(input string tag, input logic id, input logic [7:0] q,
                             input logic [7:0] r, input logic e);
      check({tag, "_valid"}, bus.resp_valid, 1);
      check({tag, "_id"}, bus.resp_id, id);
      check({tag, "_quot"}, bus.resp_quot, q);
      check({tag, "_rem"}, bus.resp_rem, r);
      check({tag, "_err"}, bus.resp_err, e);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      reset_n = 1'b0;
      bus.req0_valid = 1'b0;
      bus.req0_a     = '0;
      bus.req0_b     = '0;
      bus.req1_valid = 1'b0;
      bus.req1_a     = '0;
      bus.req1_b     = '0;
      bus.resp_ready = 1'b0;
      tick();
      tick();

      check("rst_valid", bus.resp_valid, 0);
      check("rst_id", bus.resp_id, 0);
      check("rst_quot", bus.resp_quot, 0);
      check("rst_rem", bus.resp_rem, 0);
      check("rst_err", bus.resp_err, 0);
      check("rst_rdy0", bus.req0_ready, 0);
      check("rst_rdy1", bus.req1_ready, 0);
      reset_n = 1'b1;
      tick();

      // single op: 23 / 5
      bus.resp_ready = 1'b1;
      bus.req0_a = 8'd23;
      bus.req0_b = 8'd5;
      bus.req0_valid = 1'b1;
      #1;
      check("single_rdy0", bus.req0_ready, 1);
      check("single_rdy1", bus.req1_ready, 0);
      tick();
      bus.req0_valid = 1'b0;
      check("single_busy_rdy0", bus.req0_ready, 0);
      wait_resp("single_lat", 5);
      check_resp("single", 1'b0, 8'd4, 8'd3, 1'b0);
      tick();
      check("single_drop", bus.resp_valid, 0);

      // divide by zero on requester 1
      bus.req1_a = 8'd9;
      bus.req1_b = 8'd0;
      bus.req1_valid = 1'b1;
      #1;
      check("dz_rdy1", bus.req1_ready, 1);
      check("dz_rdy0", bus.req0_ready, 0);
      tick();
      bus.req1_valid = 1'b0;
      wait_resp("dz_lat", 1);
      check_resp("dz", 1'b1, 8'hFF, 8'd9, 1'b1);
      tick();

      // contention: grants alternate starting with 0
      bus.req0_a = 8'd6;
      bus.req0_b = 8'd3;
      bus.req1_a = 8'd6;
      bus.req1_b = 8'd3;
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         check("cont_rdy0", bus.req0_ready, (k % 2 == 0) ? 1 : 0);
         check("cont_rdy1", bus.req1_ready, (k % 2 == 1) ? 1 : 0);
         tick();
         check("cont_busy_both", {bus.req0_ready, bus.req1_ready}, 0);
         wait_resp("cont_lat", 3);
         check_resp("cont", (k % 2 == 1), 8'd2, 8'd0, 1'b0);
         tick();
      end
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;

      // a < b
      bus.req0_a = 8'd3;
      bus.req0_b = 8'd7;
      bus.req0_valid = 1'b1;
      tick();
      bus.req0_valid = 1'b0;
      wait_resp("small_lat", 1);
      check_resp("small", 1'b0, 8'd0, 8'd3, 1'b0);
      tick();

      // maximum quotient
      bus.req1_a = 8'd255;
      bus.req1_b = 8'd1;
      bus.req1_valid = 1'b1;
      tick();
      bus.req1_valid = 1'b0;
      wait_resp("max_lat", 256);
      check_resp("max", 1'b1, 8'd255, 8'd0, 1'b0);
      tick();

      // backpressure: 10 / 3 held for 4 cycles with a pending request
      bus.resp_ready = 1'b0;
      bus.req0_a = 8'd10;
      bus.req0_b = 8'd3;
      bus.req0_valid = 1'b1;
      tick();
      bus.req0_valid = 1'b0;
      wait_resp("bp_lat", 4);
      bus.req1_a = 8'd5;
      bus.req1_b = 8'd5;
      bus.req1_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         check_resp("bp_hold", 1'b0, 8'd3, 8'd1, 1'b0);
         check("bp_rdy", {bus.req0_ready, bus.req1_ready}, 0);
         if (i < 3) tick();
      end
      bus.resp_ready = 1'b1;
      tick();
      check("bp_release_valid", bus.resp_valid, 0);
      check("bp_release_rdy1", bus.req1_ready, 1);
      tick();
      bus.req1_valid = 1'b0;
      wait_resp("bp_next_lat", 2);
      check_resp("bp_next", 1'b1, 8'd1, 8'd0, 1'b0);
      tick();

      // reset in the middle of a long operation
      bus.req1_a = 8'd200;
      bus.req1_b = 8'd1;
      bus.req1_valid = 1'b1;
      tick();
      bus.req1_valid = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      check("mid_rem", bus.resp_rem, 195);
      check("mid_id", bus.resp_id, 1);
      #3;
      reset_n = 1'b0;
      #1;
      check("mid_rst_rem", bus.resp_rem, 0);
      check("mid_rst_quot", bus.resp_quot, 0);
      check("mid_rst_id", bus.resp_id, 0);
      check("mid_rst_valid", bus.resp_valid, 0);
      tick();
      reset_n = 1'b1;
      begin
         int seen;
         seen = 0;
         for (int i = 0; i < 300; i++) begin
            tick();
            if (bus.resp_valid === 1'b1) seen++;
         end
         check("mid_no_resp", seen, 0);
      end
      bus.req0_a = 8'd6;
      bus.req0_b = 8'd3;
      bus.req1_a = 8'd6;
      bus.req1_b = 8'd3;
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1;
      #1;
      check("post_rst_rdy0", bus.req0_ready, 1);
      check("post_rst_rdy1", bus.req1_ready, 0);
      tick();
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      wait_resp("post_rst_lat", 3);
      check_resp("post_rst", 1'b0, 8'd2, 8'd0, 1'b0);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mod_sched.md
# mod_sched

Sequencer and round-robin arbiter for the repeated-subtraction modulo/divide datapath. It shares one subtractor between two requesters and accepts operands over a valid/ready handshake. It steps the remainder and quotient registers one subtraction per cycle until the remainder falls below the divisor, then returns quotient, remainder and error flag over a held response handshake. It sits between the ALU front-end issue logic and the shared modulo datapath.

## Interface
Parameters:
- WIDTH, 8, operand, quotient and remainder width in bits.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  reset; one clock; reset is asynchronous and active-low.
- req0_valid  in  1  requester 0 has operands.
- req0_ready  out  1  requester 0 operands accepted this cycle.
- req0_a  in  WIDTH  requester 0 dividend.
- req0_b  in  WIDTH  requester 0 divisor.
- req1_valid  in  1  requester 1 has operands.
- req1_ready  out  1  requester 1 operands accepted this cycle.
- req1_a  in  WIDTH  requester 1 dividend.
- req1_b  in  WIDTH  requester 1 divisor.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer takes the result.
- resp_id  out  1  requester that owns the result.
- resp_quot  out  WIDTH  quotient, floor(a/b).
- resp_rem  out  WIDTH  remainder, a mod b.
- resp_err  out  1  divisor was zero.

## Operation
- States:
  - IDLE: arbitrating.
  - SUB: stepping the datapath.
  - DONE: holding the response.
- Reset value: IDLE.
- IDLE:
  - Grant selection uses last_grant, which resets to 1.
  - Only req0 valid → grant 0.
  - Only req1 valid → grant 1.
  - Both valid → grant !last_grant.
  - reqN_ready = (state==IDLE) && grant==N. Ready is combinational from the valids and may not be asserted for both requesters in the same cycle.
- Acceptance edge (valid && ready):
  - rem ← a, div ← b, quot ← 0, id ← grant, last_grant ← grant, err ← 0.
  - Go to SUB.
- SUB, evaluated in priority order:
  - div==0 → err ← 1, quot ← all ones, rem unchanged (= a); go to DONE.
  - rem ≥ div → rem ← rem − div, quot ← quot + 1; stay in SUB.
  - Otherwise → go to DONE.
- DONE:
  - resp_valid = 1.
  - resp_id, resp_quot, resp_rem and resp_err are driven from the registers and held stable until the handshake.
  - Edge with resp_ready=1 → go to IDLE.
- Arithmetic:
  - Unsigned only.
  - The comparison is a full WIDTH-bit unsigned ≥.
  - The subtraction never underflows because it is gated by the comparison.
  - quot cannot overflow: the maximum is 2^WIDTH−1, at b=1.
- Both reqN_ready = 0 outside IDLE. Valids arriving during SUB or DONE wait; requesters must hold their operands stable while valid and not ready.
- Reset at any point:
  - All registers clear immediately, regardless of CLK.
  - state = IDLE, resp_valid = 0, outputs 0, last_grant = 1.
  - An in-flight operation is dropped with no response.

## Timing
- Reset values: req0_ready/req1_ready follow the IDLE arbitration; resp_valid, resp_id, resp_quot, resp_rem and resp_err are all 0.
- Latency from the acceptance edge E0 to resp_valid high:
  - b≠0: q+1 cycles, where q = floor(a/b). resp_valid is seen after edge E(q+1).
  - b=0: 1 cycle.
- resp_valid stays high for exactly the cycles up to and including the resp_ready edge, and is low in the cycle after.
- Minimum issue interval is 3 cycles (IDLE, SUB, DONE with resp_ready already high). A new acceptance can occur at the first edge in IDLE after DONE.
- resp_ready high while not in DONE has no effect.

## Structure
- Package mod_sched_pkg:
  - state enum {IDLE, SUB, DONE}, 2 bits.
  - Default WIDTH localparam.
  - Error quotient constant (all ones).
- Sub-module mod_sched_dp: registers rem, div and quot, the subtractor and the ≥ comparator, with controls load and step and status less_than / div_zero.
- mod_sched holds the FSM, the arbiter, last_grant and the id/err registers, and instantiates mod_sched_dp.

## Test plan
- Single op: req0 a=23, b=5, resp_ready=1 → after 5 cycles (q=4, so 4+1) resp_valid with id=0, quot=4, rem=3, err=0; back in IDLE on the next edge.
- Divide by zero: req1 a=9, b=0 → resp_valid 1 cycle after acceptance with id=1, err=1, quot=8'hFF, rem=9.
- Contention: req0 and req1 both valid continuously, each a=6, b=3 → grants alternate 0,1,0,1 starting with 0; req0_ready and req1_ready are never high together.
- Edge cases:
  - a=3, b=7 → quot=0, rem=3 after 1 cycle.
  - a=255, b=1 → quot=255, rem=0 after 256 cycles.
- Backpressure: resp_ready held low 4 cycles in DONE → resp fields stable, both readys low, new request not accepted until after the resp_ready edge.
- Reset mid-op: pull reset_n low between clock edges during SUB of a=200, b=1 → outputs clear immediately; no response after release; the next request is granted to req0.
